// File: rtl/custom_ip_reg_pkg.sv
// Shared constants, types and helpers for the custom IP register bridge.
// Offsets are byte offsets; only bits [4:2] select a register.
package custom_ip_reg_pkg;

    localparam int NUM_WORDS = 3;
    localparam int WORD_W    = 32;

    localparam logic [4:0] WDATA0_OFF = 5'h00;
    localparam logic [4:0] WDATA1_OFF = 5'h04;
    localparam logic [4:0] WDATA2_OFF = 5'h08;
    localparam logic [4:0] RDATA0_OFF = 5'h0C;
    localparam logic [4:0] RDATA1_OFF = 5'h10;
    localparam logic [4:0] RDATA2_OFF = 5'h14;
    localparam logic [4:0] STATUS_OFF = 5'h18;
    localparam logic [4:0] CLEAR_OFF  = 5'h1C;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_LOW
    } chan_state_e;

    // Word 0 lives in the top slice of the IP bus.
    function automatic int slice_of(input int k);
        return (NUM_WORDS - 1 - k) * WORD_W;
    endfunction

    function automatic logic [2:0] idx_of(input logic [4:0] off);
        return off[4:2];
    endfunction

endpackage

// File: rtl/custom_ip_req_chan.sv
// One 4-phase req/ack channel toward the custom IP.
// req is a registered level; it drops asynchronously on reset.
module custom_ip_req_chan
    import custom_ip_reg_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic ack_i,
    output logic busy_o,
    output logic req_o
);

    chan_state_e state_q;
    logic        req_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_i) begin
                        state_q <= WAIT_LOW;
                        req_q   <= 1'b0;
                    end
                end
                WAIT_LOW: begin
                    if (!ack_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = (state_q != IDLE);
    assign req_o  = req_q;

endmodule

// File: rtl/custom_ip_reg_bridge.sv
// Zero wait-state APB register bridge toward the custom IP:
// three write words with req/ack handshakes, three captured read words.
module custom_ip_reg_bridge
    import custom_ip_reg_pkg::*;
#(
    parameter int DATA_WIDTH     = 96,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [31:0]               pwdata_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [DATA_WIDTH-1:0]     reg2ip_data_o,
    output logic [2:0]                reg2ip_req_o,
    input  logic [2:0]                reg2ip_ack_i,
    input  logic [DATA_WIDTH-1:0]     ip2reg_data_i,
    input  logic [2:0]                ip2reg_valid_i
);

    if (DATA_WIDTH != NUM_WORDS * WORD_W) begin : g_bad_width
        $error("DATA_WIDTH must be 96");
    end

    logic [WORD_W-1:0]    wdata_q [NUM_WORDS];
    logic [WORD_W-1:0]    wdata_d [NUM_WORDS];
    logic [WORD_W-1:0]    rdata_q [NUM_WORDS];
    logic [WORD_W-1:0]    rdata_d [NUM_WORDS];
    logic [NUM_WORDS-1:0] rd_valid_q, rd_valid_d;
    logic [NUM_WORDS-1:0] rd_ovf_q, rd_ovf_d;

    logic                 access, mapped, wr, rd;
    logic [2:0]           idx;
    logic [NUM_WORDS-1:0] wsel, rsel, busy, start, rd_clr, ovf_clr;
    logic                 ssel, csel;
    logic [31:0]          status;
    logic                 unused_addr;

    assign access      = psel_i & penable_i;
    assign mapped      = ~|paddr_i[APB_ADDR_WIDTH-1:5];
    assign idx         = paddr_i[4:2];
    assign wr          = access & pwrite_i & mapped;
    assign rd          = access & ~pwrite_i & mapped;
    assign unused_addr = ^paddr_i[1:0];
    assign pready_o    = 1'b1;

    always_comb begin
        wsel = '0;
        rsel = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            wsel[k] = (idx == idx_of(WDATA0_OFF) + 3'(k));
            rsel[k] = (idx == idx_of(RDATA0_OFF) + 3'(k));
        end
        ssel = (idx == idx_of(STATUS_OFF));
        csel = (idx == idx_of(CLEAR_OFF));
    end

    assign start   = {NUM_WORDS{wr}} & wsel & ~busy;
    assign rd_clr  = {NUM_WORDS{rd}} & rsel;
    assign ovf_clr = {NUM_WORDS{wr & csel}} & pwdata_i[10:8];
    assign status  = {21'b0, rd_ovf_q, 1'b0, rd_valid_q, 1'b0, busy};

    // Writes to read-only registers or to a busy channel are refused.
    assign pslverr_o = access & (~mapped | (pwrite_i &
                       (|rsel | ssel | |(wsel & busy))));

    always_comb begin
        prdata_o = '0;
        if (rd) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (wsel[k]) prdata_o = wdata_q[k];
                if (rsel[k]) prdata_o = rdata_q[k];
            end
            if (ssel) prdata_o = status;
        end
    end

    // A capture racing a read keeps valid set; a set beats a clear.
    always_comb begin
        for (int k = 0; k < NUM_WORDS; k++) begin
            wdata_d[k]    = start[k] ? pwdata_i : wdata_q[k];
            rdata_d[k]    = rdata_q[k];
            rd_valid_d[k] = rd_valid_q[k];
            rd_ovf_d[k]   = rd_ovf_q[k] & ~ovf_clr[k];
            if (ip2reg_valid_i[k]) begin
                rdata_d[k]    = ip2reg_data_i[slice_of(k) +: WORD_W];
                rd_valid_d[k] = 1'b1;
                if (rd_valid_q[k] && !rd_clr[k]) rd_ovf_d[k] = 1'b1;
            end else if (rd_clr[k]) begin
                rd_valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                wdata_q[k] <= '0;
                rdata_q[k] <= '0;
            end
            rd_valid_q <= '0;
            rd_ovf_q   <= '0;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                wdata_q[k] <= wdata_d[k];
                rdata_q[k] <= rdata_d[k];
            end
            rd_valid_q <= rd_valid_d;
            rd_ovf_q   <= rd_ovf_d;
        end
    end

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_chan
        custom_ip_req_chan u_chan (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .start_i(start[k]),
            .ack_i  (reg2ip_ack_i[k]),
            .busy_o (busy[k]),
            .req_o  (reg2ip_req_o[k])
        );
        assign reg2ip_data_o[slice_of(k) +: WORD_W] = wdata_q[k];
    end

endmodule

// File: tb/tb_custom_ip_reg_bridge.sv
// Self-checking bench for custom_ip_reg_bridge: APB vector table
// plus hand-written handshake and capture sequences.
module tb_custom_ip_reg_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [95:0] r2i_data;
    logic [2:0]  r2i_req;
    logic [2:0]  r2i_ack = '0;
    logic [95:0] i2r_data = '0;
    logic [2:0]  i2r_valid = '0;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        is_read;
        logic [31:0] erd;
        logic        eerr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    custom_ip_reg_bridge dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .paddr_i       (paddr),
        .psel_i        (psel),
        .penable_i     (penable),
        .pwrite_i      (pwrite),
        .pwdata_i      (pwdata),
        .prdata_o      (prdata),
        .pready_o      (pready),
        .pslverr_o     (pslverr),
        .reg2ip_data_o (r2i_data),
        .reg2ip_req_o  (r2i_req),
        .reg2ip_ack_i  (r2i_ack),
        .ip2reg_data_i (i2r_data),
        .ip2reg_valid_i(i2r_valid)
    );

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One APB access; vp/vd pulse ip2reg_valid_i in the completing cycle.
    task automatic apb(input logic w, input logic [11:0] a,
                       input logic [31:0] d, input logic [31:0] erd,
                       input logic eerr, input logic [2:0] vp,
                       input logic [95:0] vd);
        exp_t e;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        sb.push_back('{is_read: !w, erd: erd, eerr: eerr});
        @(negedge clk);
        penable = 1'b1;
        i2r_valid = vp;
        if (vp != 0) i2r_data = vd;
        #1;
        e = sb.pop_front();
        chk($sformatf("pready@%0h", a), {95'b0, pready}, 96'd1);
        chk($sformatf("pslverr@%0h", a), {95'b0, pslverr}, {95'b0, e.eerr});
        if (e.is_read)
            chk($sformatf("prdata@%0h", a), {64'b0, prdata}, {64'b0, e.erd});
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; i2r_valid = '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      input logic eerr);
        apb(1'b1, a, d, 32'h0, eerr, 3'b000, 96'h0);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] erd);
        apb(1'b0, a, 32'h0, erd, 1'b0, 3'b000, 96'h0);
    endtask

    task automatic pulse(input logic [2:0] v, input logic [95:0] d);
        @(negedge clk);
        i2r_valid = v; i2r_data = d;
        @(negedge clk);
        i2r_valid = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 12'h018, 32'h0,   32'h0, 1'b0};
        tbl[1] = '{1'b0, 12'h000, 32'h0,   32'h0, 1'b0};
        tbl[2] = '{1'b0, 12'h01C, 32'h0,   32'h0, 1'b0};
        tbl[3] = '{1'b1, 12'h018, 32'hFF,  32'h0, 1'b1};
        tbl[4] = '{1'b1, 12'h00C, 32'h1,   32'h0, 1'b1};
        tbl[5] = '{1'b0, 12'h020, 32'h0,   32'h0, 1'b1};
        tbl[6] = '{1'b1, 12'h100, 32'h55,  32'h0, 1'b1};
        tbl[7] = '{1'b0, 12'h014, 32'h0,   32'h0, 1'b0};
        tbl[8] = '{1'b1, 12'h01C, 32'h700, 32'h0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {93'b0, r2i_req}, 96'h0);
        chk("rst_data", r2i_data, 96'h0);
        chk("rst_prdata", {64'b0, prdata}, 96'h0);
        chk("rst_pslverr", {95'b0, pslverr}, 96'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            apb(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].erd, tbl[i].eerr,
                3'b000, 96'h0);
        chk("tbl_req", {93'b0, r2i_req}, 96'h0);
        chk("tbl_data", r2i_data, 96'h0);

        // Handshake on word 0, ack two cycles after req.
        wr(12'h000, 32'hDEADBEEF, 1'b0);
        chk("w0_data", {64'b0, r2i_data[95:64]}, 96'hDEADBEEF);
        chk("w0_req_c1", {93'b0, r2i_req}, 96'h1);
        cyc();
        chk("w0_req_c2", {93'b0, r2i_req}, 96'h1);
        r2i_ack[0] = 1'b1;
        cyc();
        chk("w0_req_low", {93'b0, r2i_req}, 96'h0);
        rd(12'h018, 32'h1);
        rd(12'h000, 32'hDEADBEEF);
        r2i_ack[0] = 1'b0;
        cyc();
        rd(12'h018, 32'h0);

        // Capture all three words, read to clear.
        pulse(3'b111, {32'hA, 32'hB, 32'hC});
        rd(12'h018, 32'h70);
        rd(12'h00C, 32'hA);
        rd(12'h010, 32'hB);
        rd(12'h014, 32'hC);
        rd(12'h018, 32'h0);

        // Overflow on word 2 and its clear.
        pulse(3'b100, {64'h0, 32'h1});
        pulse(3'b100, {64'h0, 32'h2});
        rd(12'h018, 32'h440);
        rd(12'h014, 32'h2);
        rd(12'h018, 32'h400);
        wr(12'h01C, 32'h400, 1'b0);
        rd(12'h018, 32'h0);

        // Capture racing an RDATA0 read.
        pulse(3'b001, {32'h5, 64'h0});
        apb(1'b0, 12'h00C, 32'h0, 32'h5, 1'b0, 3'b001, {32'h6, 64'h0});
        rd(12'h018, 32'h10);
        rd(12'h00C, 32'h6);
        rd(12'h018, 32'h0);

        // Overflow set racing a CLEAR write on word 1.
        pulse(3'b010, {32'h0, 32'h7, 32'h0});
        pulse(3'b010, {32'h0, 32'h8, 32'h0});
        apb(1'b1, 12'h01C, 32'h200, 32'h0, 1'b0, 3'b010,
            {32'h0, 32'h9, 32'h0});
        rd(12'h018, 32'h220);
        rd(12'h010, 32'h9);
        wr(12'h01C, 32'h200, 1'b0);

        // Busy channel refuses a second write.
        wr(12'h004, 32'h11111111, 1'b0);
        wr(12'h004, 32'h22222222, 1'b1);
        chk("w1_kept", {64'b0, r2i_data[63:32]}, 96'h11111111);
        chk("w1_req", {93'b0, r2i_req}, 96'h2);

        // Reset while word 1 is in REQ.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_req", {93'b0, r2i_req}, 96'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(12'h018, 32'h0);

        // Stale ack held high across a new write.
        r2i_ack[1] = 1'b1;
        wr(12'h004, 32'h33333333, 1'b0);
        chk("stale_req_hi", {93'b0, r2i_req}, 96'h2);
        cyc();
        chk("stale_req_lo", {93'b0, r2i_req}, 96'h0);
        rd(12'h018, 32'h2);
        r2i_ack[1] = 1'b0;
        cyc();
        rd(12'h018, 32'h0);
        chk("stale_data", {64'b0, r2i_data[63:32]}, 96'h33333333);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
